// File: rtl/pd_debug_auth_host_driver.sv
// Host-side driver: round-robin arbitration among requesting channels, streams each
// channel's certificate chunks from a message ROM to the auth controller, captures its response.
//
// state   | meaning
// IDLE    | no session; arbitrate among req_valid
// FETCH   | rom_addr settled; rom_data latched at the closing edge
// PRESENT | chunk valid; wait for auth_msg_ready or hold timeout
// ACK     | Ack_in_driver high; advance to next chunk or end the chain
module pd_debug_auth_host_driver #(
  parameter int MSG_LEN     = 64,
  parameter int NUM_CH      = 2,
  parameter int NUM_CHUNKS  = 6,
  parameter int HOLD_CYCLES = 30,
  localparam int ADDR_W = (NUM_CH * NUM_CHUNKS > 1) ? $clog2(NUM_CH * NUM_CHUNKS) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_CH-1:0]  req_valid,
  output logic [NUM_CH-1:0]  grant,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [MSG_LEN-1:0] rom_data,
  output logic [MSG_LEN-1:0] auth_msg_in,
  output logic [NUM_CH-1:0]  msg_ready,
  input  logic               auth_msg_ready,
  output logic               Ack_in_driver,
  input  logic               resp_req_out,
  input  logic [MSG_LEN-1:0] auth_msg_out,
  output logic               resp_req_in,
  output logic [MSG_LEN-1:0] resp_msg,
  output logic               resp_valid,
  output logic [NUM_CH-1:0]  chan_done,
  output logic [NUM_CH-1:0]  timeout_err
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int IDX_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, FETCH, PRESENT, ACK} state_t;

  state_t             state_q, state_d;
  logic [CH_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [CH_W-1:0]    ch_q, ch_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [NUM_CH-1:0]  grant_q, grant_d;
  logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
  logic [MSG_LEN-1:0] auth_msg_in_q, auth_msg_in_d;
  logic [NUM_CH-1:0]  msg_ready_q, msg_ready_d;
  logic [NUM_CH-1:0]  chan_done_q, chan_done_d;
  logic [NUM_CH-1:0]  timeout_err_q, timeout_err_d;
  logic               resp_req_in_q, resp_req_in_d;
  logic [MSG_LEN-1:0] resp_msg_q, resp_msg_d;
  logic               resp_valid_q, resp_valid_d;

  logic               sel_found;
  logic [CH_W-1:0]    sel_ch, cand_ch;
  logic               rearm;

  // Round-robin search starting one past the last served channel.
  always_comb begin
    sel_found = 1'b0;
    sel_ch    = '0;
    cand_ch   = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      cand_ch = CH_W'((int'(rr_ptr_q) + i) % NUM_CH);
      if (!sel_found && req_valid[cand_ch]) begin
        sel_found = 1'b1;
        sel_ch    = cand_ch;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    ch_d          = ch_q;
    idx_d         = idx_q;
    hold_cnt_d    = hold_cnt_q;
    grant_d       = grant_q;
    rom_addr_d    = rom_addr_q;
    auth_msg_in_d = auth_msg_in_q;
    msg_ready_d   = msg_ready_q;
    chan_done_d   = '0;
    timeout_err_d = timeout_err_q;
    rearm         = 1'b0;

    case (state_q)
      IDLE: begin
        if (sel_found) begin
          grant_d               = '0;
          grant_d[sel_ch]       = 1'b1;
          rr_ptr_d              = sel_ch;
          ch_d                  = sel_ch;
          timeout_err_d[sel_ch] = 1'b0;
          idx_d                 = '0;
          rom_addr_d            = ADDR_W'(int'(sel_ch) * NUM_CHUNKS);
          state_d               = FETCH;
        end
      end
      FETCH: begin
        auth_msg_in_d     = rom_data;
        msg_ready_d       = '0;
        msg_ready_d[ch_q] = 1'b1;
        hold_cnt_d        = '0;
        state_d           = PRESENT;
      end
      PRESENT: begin
        // Ready is checked first so a late ready on the last hold cycle still completes.
        if (auth_msg_ready) begin
          msg_ready_d = '0;
          state_d     = ACK;
        end else if (hold_cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
          msg_ready_d         = '0;
          timeout_err_d[ch_q] = 1'b1;
          grant_d             = '0;
          state_d             = IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end
      ACK: begin
        if (idx_q == IDX_W'(NUM_CHUNKS - 1)) begin
          chan_done_d[ch_q] = 1'b1;
          grant_d           = '0;
          rearm             = 1'b1;
          state_d           = IDLE;
        end else begin
          idx_d      = idx_q + IDX_W'(1);
          rom_addr_d = ADDR_W'(int'(ch_q) * NUM_CHUNKS + int'(idx_q) + 1);
          state_d    = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A new response request on the same edge as a chain completion takes precedence.
  always_comb begin
    resp_valid_d  = resp_req_out;
    resp_msg_d    = resp_msg_q;
    resp_req_in_d = resp_req_in_q;
    if (resp_req_out) begin
      resp_req_in_d = 1'b0;
      resp_msg_d    = auth_msg_out;
    end else if (rearm) begin
      resp_req_in_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      rr_ptr_q      <= CH_W'(NUM_CH - 1);
      ch_q          <= '0;
      idx_q         <= '0;
      hold_cnt_q    <= '0;
      grant_q       <= '0;
      rom_addr_q    <= '0;
      auth_msg_in_q <= '0;
      msg_ready_q   <= '0;
      chan_done_q   <= '0;
      timeout_err_q <= '0;
      resp_req_in_q <= 1'b1;
      resp_msg_q    <= '0;
      resp_valid_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      ch_q          <= ch_d;
      idx_q         <= idx_d;
      hold_cnt_q    <= hold_cnt_d;
      grant_q       <= grant_d;
      rom_addr_q    <= rom_addr_d;
      auth_msg_in_q <= auth_msg_in_d;
      msg_ready_q   <= msg_ready_d;
      chan_done_q   <= chan_done_d;
      timeout_err_q <= timeout_err_d;
      resp_req_in_q <= resp_req_in_d;
      resp_msg_q    <= resp_msg_d;
      resp_valid_q  <= resp_valid_d;
    end
  end

  assign grant         = grant_q;
  assign rom_addr      = rom_addr_q;
  assign auth_msg_in   = auth_msg_in_q;
  assign msg_ready     = msg_ready_q;
  assign Ack_in_driver = (state_q == ACK);
  assign chan_done     = chan_done_q;
  assign timeout_err   = timeout_err_q;
  assign resp_req_in   = resp_req_in_q;
  assign resp_msg      = resp_msg_q;
  assign resp_valid    = resp_valid_q;

endmodule

// File: tb/tb_pd_debug_auth_host_driver.sv
// Bench for pd_debug_auth_host_driver: ROM model (word = address + 1), a negedge monitor
// that scores presented chunks against a queue, and directed sessions.
module tb_pd_debug_auth_host_driver;
  localparam int MSG_LEN     = 64;
  localparam int NUM_CH      = 2;
  localparam int NUM_CHUNKS  = 6;
  localparam int HOLD_CYCLES = 30;
  localparam int ADDR_W      = $clog2(NUM_CH * NUM_CHUNKS);

  logic               clk = 1'b0;
  logic               reset;
  logic [NUM_CH-1:0]  req_valid;
  logic [NUM_CH-1:0]  grant;
  logic [ADDR_W-1:0]  rom_addr;
  logic [MSG_LEN-1:0] rom_data;
  logic [MSG_LEN-1:0] auth_msg_in;
  logic [NUM_CH-1:0]  msg_ready;
  logic               auth_msg_ready;
  logic               Ack_in_driver;
  logic               resp_req_out;
  logic [MSG_LEN-1:0] auth_msg_out;
  logic               resp_req_in;
  logic [MSG_LEN-1:0] resp_msg;
  logic               resp_valid;
  logic [NUM_CH-1:0]  chan_done;
  logic [NUM_CH-1:0]  timeout_err;

  pd_debug_auth_host_driver #(
    .MSG_LEN(MSG_LEN), .NUM_CH(NUM_CH), .NUM_CHUNKS(NUM_CHUNKS), .HOLD_CYCLES(HOLD_CYCLES)
  ) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .grant(grant), .rom_addr(rom_addr),
    .rom_data(rom_data), .auth_msg_in(auth_msg_in), .msg_ready(msg_ready),
    .auth_msg_ready(auth_msg_ready), .Ack_in_driver(Ack_in_driver),
    .resp_req_out(resp_req_out), .auth_msg_out(auth_msg_out), .resp_req_in(resp_req_in),
    .resp_msg(resp_msg), .resp_valid(resp_valid), .chan_done(chan_done),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  always_comb rom_data = 64'(rom_addr) + 64'd1;

  typedef struct {
    int          ch;
    logic [63:0] data;
  } sb_item_t;

  sb_item_t sb_q[$];
  int       gseq[$];
  int       first_addr[$];

  int n_chk = 0;
  int n_err = 0;

  // 0: never ready, 1: ready on first PRESENT cycle, 2: ready on the last hold cycle
  int ready_mode = 1;
  int ack_cnt = 0;
  int done_cnt[NUM_CH];
  int pres_cnt = 0;
  int last_pres_len = 0;
  int gcnt = 0;
  int last_gcnt = 0;
  logic done_rri = 1'b0;
  logic done_prev_rri = 1'b0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic push_chain(input int ch);
    for (int k = 0; k < NUM_CHUNKS; k++) begin
      sb_item_t it;
      it.ch   = ch;
      it.data = 64'(ch * NUM_CHUNKS + k + 1);
      sb_q.push_back(it);
    end
  endtask

  task automatic push_first(input int ch);
    sb_item_t it;
    it.ch   = ch;
    it.data = 64'(ch * NUM_CHUNKS + 1);
    sb_q.push_back(it);
  endtask

  task automatic wait_grant(input string tag, input int budget);
    for (int i = 0; i < budget && grant == '0; i++) @(negedge clk);
    chk(tag, 64'(grant != '0), 64'd1);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    for (int i = 0; i < budget && grant != '0; i++) @(negedge clk);
    chk(tag, 64'(grant), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // Monitor: drives auth_msg_ready, scores chunks, counts pulses.
  initial begin
    logic [NUM_CH-1:0] prev_mr;
    logic [NUM_CH-1:0] prev_grant;
    logic              prev_rri;
    prev_mr        = '0;
    prev_grant     = '0;
    prev_rri       = 1'b1;
    auth_msg_ready = 1'b0;
    for (int c = 0; c < NUM_CH; c++) done_cnt[c] = 0;
    forever begin
      @(negedge clk);
      if (msg_ready != '0) begin
        if (prev_mr == '0) begin
          pres_cnt = 0;
          if (sb_q.size() == 0) begin
            chk("sb_underflow", 64'(sb_q.size()), 64'd1);
          end else begin
            sb_item_t it;
            it = sb_q.pop_front();
            chk("chunk_data", auth_msg_in, it.data);
            chk("chunk_flag", 64'(msg_ready), 64'd1 << it.ch);
            chk("chunk_grant", 64'(grant), 64'd1 << it.ch);
          end
        end
        pres_cnt++;
      end else if (prev_mr != '0) begin
        last_pres_len = pres_cnt;
      end
      case (ready_mode)
        1:       auth_msg_ready = (msg_ready != '0);
        2:       auth_msg_ready = (msg_ready != '0) && (pres_cnt == HOLD_CYCLES);
        default: auth_msg_ready = 1'b0;
      endcase
      if (Ack_in_driver) ack_cnt++;
      for (int c = 0; c < NUM_CH; c++) if (chan_done[c]) done_cnt[c]++;
      if (chan_done != '0) begin
        done_rri      = resp_req_in;
        done_prev_rri = prev_rri;
      end
      if (grant != '0) begin
        if (prev_grant == '0) begin
          gseq.push_back(grant[1] ? 1 : 0);
          first_addr.push_back(int'(rom_addr));
          gcnt = 0;
        end
        gcnt++;
      end else if (prev_grant != '0) begin
        last_gcnt = gcnt;
      end
      prev_mr    = msg_ready;
      prev_grant = grant;
      prev_rri   = resp_req_in;
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation exceeded time limit, errors=%0d", n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, d0, d1, g0;
    reset        = 1'b1;
    req_valid    = '0;
    resp_req_out = 1'b0;
    auth_msg_out = '0;
    repeat (3) @(negedge clk);

    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_msg_ready", 64'(msg_ready), 64'd0);
    chk("rst_ack", 64'(Ack_in_driver), 64'd0);
    chk("rst_chan_done", 64'(chan_done), 64'd0);
    chk("rst_timeout", 64'(timeout_err), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_auth_msg_in", auth_msg_in, 64'd0);
    chk("rst_resp_msg", resp_msg, 64'd0);
    chk("rst_rom_addr", 64'(rom_addr), 64'd0);
    chk("rst_resp_req_in", 64'(resp_req_in), 64'd1);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_grant", 64'(grant), 64'd0);
    chk("idle_resp_req_in", 64'(resp_req_in), 64'd1);
    chk("idle_msg_ready", 64'(msg_ready), 64'd0);

    // Single chain on channel 0 with latency checks
    a0 = ack_cnt; d0 = done_cnt[0];
    push_chain(0);
    req_valid = 2'b01;
    @(negedge clk);
    chk("lat_grant", 64'(grant), 64'd1);
    chk("lat_rom_addr", 64'(rom_addr), 64'd0);
    chk("lat_msg_ready_early", 64'(msg_ready), 64'd0);
    req_valid = 2'b00;
    @(negedge clk);
    chk("lat_msg_ready", 64'(msg_ready), 64'd1);
    chk("lat_auth_msg_in", auth_msg_in, 64'd1);
    wait_idle("single_idle", 60);
    chk("single_acks", 64'(ack_cnt - a0), 64'd6);
    chk("single_done0", 64'(done_cnt[0] - d0), 64'd1);
    chk("single_len", 64'(last_gcnt), 64'd18);
    chk("single_sb_empty", 64'(sb_q.size()), 64'd0);

    // Round-robin from a fresh reset: 0, 1, 0
    do_reset();
    a0 = ack_cnt; d0 = done_cnt[0]; d1 = done_cnt[1]; g0 = gseq.size();
    push_chain(0); push_chain(1); push_chain(0);
    req_valid = 2'b11;
    for (int i = 0; i < 100 && gseq.size() < g0 + 3; i++) @(negedge clk);
    chk("rr_sessions", 64'(gseq.size() - g0), 64'd3);
    req_valid = 2'b00;
    wait_idle("rr_idle", 60);
    if (gseq.size() >= g0 + 3) begin
      chk("rr_first", 64'(gseq[g0]), 64'd0);
      chk("rr_second", 64'(gseq[g0 + 1]), 64'd1);
      chk("rr_third", 64'(gseq[g0 + 2]), 64'd0);
      chk("rr_ch1_addr", 64'(first_addr[g0 + 1]), 64'd6);
    end
    chk("rr_acks", 64'(ack_cnt - a0), 64'd18);
    chk("rr_done0", 64'(done_cnt[0] - d0), 64'd2);
    chk("rr_done1", 64'(done_cnt[1] - d1), 64'd1);

    // Timeout on channel 0
    ready_mode = 0;
    a0 = ack_cnt; d0 = done_cnt[0];
    push_first(0);
    req_valid = 2'b01;
    wait_grant("to_grant", 10);
    req_valid = 2'b00;
    wait_idle("to_idle", 60);
    chk("to_pres_len", 64'(last_pres_len), 64'd30);
    chk("to_err", 64'(timeout_err), 64'd1);
    chk("to_no_ack", 64'(ack_cnt - a0), 64'd0);
    chk("to_no_done", 64'(done_cnt[0] - d0), 64'd0);
    chk("to_msg_ready", 64'(msg_ready), 64'd0);

    // Response capture
    auth_msg_out = 64'hA5A5_0000_0000_5A5A;
    resp_req_out = 1'b1;
    @(negedge clk);
    resp_req_out = 1'b0;
    chk("resp_valid_pulse", 64'(resp_valid), 64'd1);
    chk("resp_req_in_clr", 64'(resp_req_in), 64'd0);
    chk("resp_msg", resp_msg, 64'hA5A5_0000_0000_5A5A);
    auth_msg_out = 64'h1111_2222_3333_4444;
    @(negedge clk);
    chk("resp_valid_end", 64'(resp_valid), 64'd0);
    chk("resp_req_in_hold", 64'(resp_req_in), 64'd0);
    chk("resp_msg_hold", resp_msg, 64'hA5A5_0000_0000_5A5A);

    // Ready on the final hold cycle: full chain, no error; also clears the sticky error
    ready_mode = 2;
    a0 = ack_cnt; d0 = done_cnt[0];
    push_chain(0);
    req_valid = 2'b01;
    wait_grant("late_grant", 10);
    chk("late_err_cleared", 64'(timeout_err), 64'd0);
    req_valid = 2'b00;
    wait_idle("late_idle", 400);
    chk("late_acks", 64'(ack_cnt - a0), 64'd6);
    chk("late_done0", 64'(done_cnt[0] - d0), 64'd1);
    chk("late_err", 64'(timeout_err), 64'd0);
    chk("late_pres_len", 64'(last_pres_len), 64'd30);
    chk("rearm_on_done", 64'(done_rri), 64'd1);
    chk("rearm_before_done", 64'(done_prev_rri), 64'd0);

    // Asynchronous reset in the middle of PRESENT
    ready_mode = 0;
    push_first(0);
    req_valid = 2'b01;
    for (int i = 0; i < 10 && msg_ready == '0; i++) @(negedge clk);
    chk("mid_present", 64'(msg_ready), 64'd1);
    req_valid    = 2'b00;
    auth_msg_out = 64'hDEAD_BEEF_0000_0001;
    resp_req_out = 1'b1;
    @(negedge clk);
    resp_req_out = 1'b0;
    chk("mid_resp_req_in", 64'(resp_req_in), 64'd0);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_grant", 64'(grant), 64'd0);
    chk("arst_msg_ready", 64'(msg_ready), 64'd0);
    chk("arst_ack", 64'(Ack_in_driver), 64'd0);
    chk("arst_auth_msg_in", auth_msg_in, 64'd0);
    chk("arst_rom_addr", 64'(rom_addr), 64'd0);
    chk("arst_resp_req_in", 64'(resp_req_in), 64'd1);
    chk("arst_resp_msg", resp_msg, 64'd0);
    chk("arst_resp_valid", 64'(resp_valid), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_grant", 64'(grant), 64'd0);
    chk("post_sb_empty", 64'(sb_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/pd_debug_auth_host_driver.md
# pd_debug_auth_host_driver

Synthesizable, parametrised host-side driver for the Type-C authentication controller. It replaces the fixed PD/DEBUG stimulus model with a real engine. It arbitrates round-robin among NUM_CH requesting channels, fetches each channel's NUM_CHUNKS-chunk certificate chain from an external message ROM, and presents the chunks one at a time with a ready/ack handshake. It also services the controller's response-request flag and captures the controller's response message. It sits between the host message store and the authentication controller's auth_msg_in / auth_msg_ready / Ack_in_driver port group.

## Interface
Parameters:
- MSG_LEN, default 64: width of one message chunk (header and payload).
- NUM_CH, default 2: number of requesting channels (channel 0 = PD, channel 1 = DEBUG).
- NUM_CHUNKS, default 6: chunks per channel chain; minimum 1.
- HOLD_CYCLES, default 30: maximum cycles a chunk is held awaiting auth_msg_ready; minimum 1.
- ADDR_W, localparam: $clog2(NUM_CH*NUM_CHUNKS), minimum 1.

Ports:
- clk, in, 1: single clock; all state changes on its rising edge.
- reset, in, 1: asynchronous, active-high.
- req_valid, in, NUM_CH: per-channel pending authentication request (level).
- grant, out, NUM_CH: one-hot channel currently being served; 0 when idle.
- rom_addr, out, ADDR_W: chunk address, equal to ch*NUM_CHUNKS + idx.
- rom_data, in, MSG_LEN: chunk data; must be valid by the end of the cycle following a rom_addr change.
- auth_msg_in, out, MSG_LEN: chunk presented to the controller.
- msg_ready, out, NUM_CH: per-channel "chunk valid" flag (generalises PD_msg_ready and DEBUG_msg_ready).
- auth_msg_ready, in, 1: controller has consumed the presented chunk.
- Ack_in_driver, out, 1: one-cycle acknowledge following a consumed chunk.
- resp_req_out, in, 1: controller requests a response.
- auth_msg_out, in, MSG_LEN: controller response message.
- resp_req_in, out, 1: host "response pending" flag.
- resp_msg, out, MSG_LEN: captured auth_msg_out.
- resp_valid, out, 1: one-cycle pulse when resp_msg updates.
- chan_done, out, NUM_CH: one-cycle pulse when a channel's chain completes.
- timeout_err, out, NUM_CH: sticky per-channel timeout flag.

## Operation
- FSM states: IDLE, FETCH, PRESENT, ACK.
- **IDLE:** if any req_valid bit is high, select the first requesting channel searching upward from rr_ptr+1, wrapping modulo NUM_CH. On that edge:
  - set grant, set rr_ptr to the selected channel, clear that channel's timeout_err;
  - set idx=0, set rom_addr, go to FETCH.
- **FETCH:** exactly 1 cycle. At its closing edge:
  - auth_msg_in <= rom_data;
  - msg_ready[ch] <= 1;
  - hold counter <= 0;
  - go to PRESENT.
- **PRESENT:**
  - If auth_msg_ready is sampled high: msg_ready <= 0, go to ACK.
  - Else if counter == HOLD_CYCLES-1: msg_ready <= 0, timeout_err[ch] <= 1, grant <= 0, go to IDLE; no Ack.
  - Else counter increments.
- **ACK:** Ack_in_driver high for exactly this cycle.
  - If idx == NUM_CHUNKS-1: chan_done[ch] pulses the next cycle, grant <= 0, go to IDLE.
  - Else idx++, rom_addr updates, go to FETCH.
- req_valid deasserting mid-session is ignored; the session runs to completion or timeout.
- Arithmetic: rom_addr is computed at ADDR_W bits. The counter is $clog2(HOLD_CYCLES+1) bits and never wraps.
- **Response path, independent of the FSM:**
  - resp_req_in is 1 out of reset.
  - resp_req_out sampled high: resp_req_in <= 0, resp_msg <= auth_msg_out, resp_valid pulses.
  - resp_req_in re-arms to 1 on the edge where a chan_done pulse is generated.

## Timing
- Reset values:
  - state IDLE, rr_ptr NUM_CH-1 (so channel 0 wins first);
  - grant, msg_ready, Ack_in_driver, chan_done, timeout_err, resp_valid: all 0;
  - auth_msg_in, resp_msg, rom_addr: 0;
  - resp_req_in: 1.
- Reset mid-session aborts immediately to these values. There is no partial Ack.
- Latency from req_valid high in IDLE:
  - grant and rom_addr change at edge +1;
  - msg_ready and auth_msg_in change at edge +2.
- Per-chunk cost with immediate auth_msg_ready is 3 cycles (FETCH, PRESENT, ACK). A full chain with NUM_CHUNKS=6 takes 18 cycles from the first FETCH to the final ACK.
- auth_msg_ready is ignored outside PRESENT.
- If auth_msg_ready arrives on the timeout cycle, ready wins (goes to ACK, no error).
- resp_req_out and FSM events may coincide; the response path never stalls the FSM.

## Test plan
- Reset, then idle: after reset deasserts, all outputs hold their reset values, with resp_req_in=1 and grant=0.
- Single chain: req_valid=2'b01, ROM word at address k = k+1, auth_msg_ready returned 1 cycle after each msg_ready.
  - auth_msg_in steps through 1..6.
  - Exactly 6 Ack_in_driver pulses.
  - chan_done[0] pulses once.
  - grant returns to 0.
- Round-robin: req_valid=2'b11 held constantly.
  - Sessions alternate channel 0, 1, 0.
  - Channel 1's first chunk reads address 6.
- Timeout: HOLD_CYCLES=30, auth_msg_ready held 0.
  - msg_ready drops after 30 cycles in PRESENT.
  - timeout_err[0]=1, no Ack, grant=0.
  - The next grant to channel 0 clears timeout_err[0].
- Ready on the timeout cycle: assert auth_msg_ready exactly on the 30th PRESENT cycle -> ACK pulses and timeout_err stays 0.
- Response path: pulse resp_req_out with auth_msg_out=64'hA5A5_0000_0000_5A5A.
  - resp_req_in goes 0 and resp_msg captures the value, with a one-cycle resp_valid pulse.
  - resp_req_in returns to 1 on the edge where the next chan_done pulse is generated.
  - Assert reset mid-PRESENT: all outputs return to reset values asynchronously.
